collector_capture_ctrl: RTL and testbench

//  Capture sequencer placed in front of data_collector. It generates the collector's we and a

---
 rtl/collector_capture_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_collector_capture_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/collector_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : collector_capture_ctrl
//  Description : Capture sequencer in front of data_collector. Arms on a
//                pulse, waits for a trigger (immediate, external rising edge
//                or masked data match on one port), then issues `length`
//                write strobes with optional decimation and reports done.
//                The write strobe and a registered copy of the packed port
//                data leave the block aligned to each other.
//  Ports       : clk, resetn           - capture clock, async active-low reset
//                arm, abort            - 1-cycle control pulses
//                length, decim         - capture length / decimation (latched at arm)
//                trig_mode, trig_ext   - trigger source select, external trigger
//                trig_port/value/mask  - data-match trigger setup
//                data_in               - packed live port data, port 0 in MSBs
//                we, data_out          - collector write strobe and data
//                busy, done, sample_cnt- status
//  Revision    : 1.0 - initial release
// ============================================================================
module collector_capture_ctrl #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 1024,
    parameter int CNT_WIDTH  = $clog2(DATA_DEPTH) + 1,
    parameter int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            arm,
    input  logic                            abort,
    input  logic [CNT_WIDTH-1:0]            length,
    input  logic [15:0]                     decim,
    input  logic [1:0]                      trig_mode,
    input  logic                            trig_ext,
    input  logic [PORT_W-1:0]               trig_port,
    input  logic [DATA_WIDTH-1:0]           trig_value,
    input  logic [DATA_WIDTH-1:0]           trig_mask,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
    output logic                            we,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
    output logic                            busy,
    output logic                            done,
    output logic [CNT_WIDTH-1:0]            sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_depth = CNT_WIDTH'(DATA_DEPTH);

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_len_l;
    logic [15:0]            r_decim_l;
    logic [15:0]            r_dc;
    logic                   r_trig_ext_q;

    logic [CNT_WIDTH-1:0]   w_len_clamped;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;
    logic [NUM_PORTS-1:0]   w_port_hit;
    logic                   w_match;
    logic                   w_ext_rise;
    logic                   w_trig;

    assign w_len_clamped = (length > c_depth) ? c_depth : length;
    assign w_cnt_inc     = sample_cnt + CNT_WIDTH'(1);

    // One hit bit per port; only the port selected by trig_port can hit, so an
    // out-of-range index simply never matches.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port_match
            logic [DATA_WIDTH-1:0] w_port;
            assign w_port = data_in[(NUM_PORTS-1-gi)*DATA_WIDTH +: DATA_WIDTH];
            assign w_port_hit[gi] = (trig_port == PORT_W'(gi)) &&
                                    (((w_port ^ trig_value) & trig_mask) == '0);
        end
    endgenerate

    assign w_match    = |w_port_hit;
    // The previous-cycle copy is kept in every state so a level already high
    // when arming cannot look like an edge.
    assign w_ext_rise = trig_ext & ~r_trig_ext_q;

    always_comb begin
        w_trig = 1'b0;
        case (trig_mode)
            2'b01:   w_trig = w_ext_rise;
            2'b10:   w_trig = w_match;
            default: w_trig = 1'b1;   // 00 and 11 are immediate
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_len_l      <= '0;
            r_decim_l    <= '0;
            r_dc         <= '0;
            r_trig_ext_q <= 1'b0;
            we           <= 1'b0;
            data_out     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_cnt   <= '0;
        end else begin
            r_trig_ext_q <= trig_ext;
            we           <= 1'b0;

            if (abort) begin
                // Abort beats any same-cycle arm or trigger; count is kept.
                r_state <= S_IDLE;
                busy    <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            r_len_l    <= w_len_clamped;
                            r_decim_l  <= decim;
                            sample_cnt <= '0;
                            if (w_len_clamped == '0) begin
                                r_state <= S_DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                r_state <= S_ARMED;
                                busy    <= 1'b1;
                                done    <= 1'b0;
                            end
                        end
                    end

                    S_ARMED: begin
                        if (w_trig) begin
                            // The trigger sample itself is the first write.
                            we         <= 1'b1;
                            data_out   <= data_in;
                            sample_cnt <= w_cnt_inc;
                            r_dc       <= r_decim_l;
                            if (w_cnt_inc == r_len_l) begin
                                r_state <= S_DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                r_state <= S_CAPTURE;
                            end
                        end
                    end

                    S_CAPTURE: begin
                        if (r_dc == '0) begin
                            we         <= 1'b1;
                            data_out   <= data_in;
                            sample_cnt <= w_cnt_inc;
                            r_dc       <= r_decim_l;
                            // Last write lands together with the DONE state.
                            if (w_cnt_inc == r_len_l) begin
                                r_state <= S_DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            r_dc <= r_dc - 16'd1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_collector_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collector_capture_ctrl
//  Description : Directed self-checking bench for collector_capture_ctrl.
//                Port data is a counter: port0 = n, port1 = 2n (8-bit wrap).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collector_capture_ctrl;

    localparam int c_cw = 11;

    logic              clk;
    logic              resetn;
    logic              arm;
    logic              abort;
    logic [c_cw-1:0]   length;
    logic [15:0]       decim;
    logic [1:0]        trig_mode;
    logic              trig_ext;
    logic [0:0]        trig_port;
    logic [7:0]        trig_value;
    logic [7:0]        trig_mask;
    logic [15:0]       data_in;
    logic              we;
    logic [15:0]       data_out;
    logic              busy;
    logic              done;
    logic [c_cw-1:0]   sample_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int dcnt    = 0;

    function automatic logic [15:0] fdata(input int v);
        logic [7:0] p0;
        logic [7:0] p1;
        int v2;
        v2 = v * 2;
        p0 = v[7:0];
        p1 = v2[7:0];
        return {p0, p1};
    endfunction

    assign data_in = fdata(dcnt);

    collector_capture_ctrl #(
        .NUM_PORTS (2),
        .DATA_WIDTH(8),
        .DATA_DEPTH(1024)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .arm        (arm),
        .abort      (abort),
        .length     (length),
        .decim      (decim),
        .trig_mode  (trig_mode),
        .trig_ext   (trig_ext),
        .trig_port  (trig_port),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .data_in    (data_in),
        .we         (we),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        dcnt++;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    int dA;
    int dT;
    int nwe;
    logic found;
    logic [15:0] last;

    initial begin
        resetn = 1'b0; arm = 1'b0; abort = 1'b0; length = '0; decim = '0;
        trig_mode = 2'b00; trig_ext = 1'b0; trig_port = 1'b0;
        trig_value = '0; trig_mask = '0;
        tick(); tick();
        check("rst_we",   we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt",  sample_cnt, 0);
        check("rst_dout", data_out, 0);
        resetn = 1'b1;
        tick();

        // ---- 1: immediate, length 4, decim 0
        length = 4; decim = 0; trig_mode = 2'b00;
        dA = dcnt;
        pulse_arm();
        check("t1_armed_we", we, 0);
        check("t1_busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_we", we, 1);
            check("t1_dout", data_out, fdata(dA + 1 + k));
            check("t1_cnt", sample_cnt, k + 1);
            check("t1_done", done, (k == 3) ? 1 : 0);
        end
        tick();
        check("t1_we_after", we, 0);
        check("t1_done_hold", done, 1);
        check("t1_busy_after", busy, 0);

        // ---- 2: external edge, level high before arm must not fire
        trig_ext = 1'b1;
        tick(); tick(); tick();
        trig_mode = 2'b01; length = 2;
        pulse_arm();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_no_early", we, 0);
        end
        trig_ext = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_low", we, 0);
        end
        trig_ext = 1'b1;
        dT = dcnt;
        check("t2_busy_wait", busy, 1);
        tick();
        check("t2_first_we", we, 1);
        check("t2_first_dout", data_out, fdata(dT));
        tick();
        check("t2_second_we", we, 1);
        check("t2_done", done, 1);
        check("t2_cnt", sample_cnt, 2);
        trig_ext = 1'b0;
        tick();

        // ---- 3: data match on port1 == 0x06, then mask 0 fires at once
        trig_mode = 2'b10; trig_port = 1'b1; trig_value = 8'h06; trig_mask = 8'hFF;
        length = 1;
        dcnt = 0;
        pulse_arm();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (we) found = 1'b1;
        end
        check("t3_found", found, 1);
        check("t3_when", dcnt, 4);
        check("t3_port1", data_out[7:0], 8'h06);
        check("t3_port0", data_out[15:8], 8'h03);
        check("t3_done", done, 1);
        trig_mask = 8'h00;
        dA = dcnt;
        pulse_arm();
        tick();
        check("t3_mask0_we", we, 1);
        check("t3_mask0_dout", data_out, fdata(dA + 1));
        tick();

        // ---- 4: length 3, decim 2
        trig_mode = 2'b00; length = 3; decim = 2;
        dA = dcnt;
        pulse_arm();
        last = 16'h0000;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("t4_we", we, (k % 3 == 0) ? 1 : 0);
            if (k % 3 == 0) last = fdata(dA + 1 + k);
            check("t4_dout", data_out, last);
        end
        check("t4_done", done, 1);
        check("t4_cnt", sample_cnt, 3);

        // ---- re-arm from DONE restarts the count
        length = 2; decim = 0;
        pulse_arm();
        check("rearm_cnt", sample_cnt, 0);
        check("rearm_done", done, 0);
        tick(); tick();
        check("rearm_cnt_end", sample_cnt, 2);
        check("rearm_done_end", done, 1);

        // ---- 5a: length 0
        length = 0;
        pulse_arm();
        check("t5_len0_done", done, 1);
        check("t5_len0_busy", busy, 0);
        check("t5_len0_we", we, 0);
        check("t5_len0_cnt", sample_cnt, 0);
        tick();
        check("t5_len0_we2", we, 0);

        // ---- 5b: length 2000 clamps to 1024; arm/length change mid-capture ignored
        length = 2000;
        pulse_arm();
        nwe = 0;
        for (int k = 0; k < 1100; k++) begin
            if (k == 100) begin arm = 1'b1; length = 5; end
            if (k == 101) arm = 1'b0;
            tick();
            if (we) nwe++;
        end
        check("t5_writes", nwe, 1024);
        check("t5_cnt", sample_cnt, 1024);
        check("t5_done", done, 1);

        // ---- 6a: abort together with an external edge
        trig_mode = 2'b01; trig_ext = 1'b0; length = 4;
        pulse_arm();
        tick();
        trig_ext = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_abort_we", we, 0);
        check("t6_abort_busy", busy, 0);
        check("t6_abort_done", done, 0);
        tick();
        check("t6_abort_we2", we, 0);
        trig_ext = 1'b0;

        // ---- 6b: abort mid-capture keeps the count
        trig_mode = 2'b00; length = 10;
        pulse_arm();
        tick(); tick(); tick();
        check("t6_mid_cnt", sample_cnt, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_mid_we", we, 0);
        check("t6_mid_keep", sample_cnt, 3);
        check("t6_mid_busy", busy, 0);

        // ---- 6c: asynchronous reset mid-capture
        pulse_arm();
        tick(); tick();
        check("t6_rst_pre_we", we, 1);
        resetn = 1'b0;
        #1;
        check("t6_rst_we", we, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_cnt", sample_cnt, 0);
        check("t6_rst_dout", data_out, 0);
        tick();
        resetn = 1'b1;
        tick();
        check("t6_rst_idle_we", we, 0);
        check("t6_rst_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
